rng_table_reader: RTL and testbench
===================================

# rng_table_reader

Consumer side of the uniform random number generator's address path. Accepts one quad of table addresses (p, q, r, s) per transaction from the address generator. Reads the four table words from a single-port synchronous RAM and combines them into one random word. Writes the result back into slot p and delivers it downstream over a valid/ready handshake.

## Interface
- AW, 10, table address width (1024-entry table)
- DW, 32, table word / output width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  address quad valid
- in_ready  out  1  block can accept a quad
- p_addr, q_addr, r_addr, s_addr  in  AW each  table addresses, sampled on accept
- mem_addr  out  AW  RAM address
- mem_rd_en  out  1  RAM read strobe; data returns on mem_rdata the next cycle
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  random word
- num_count  out  16  results delivered since reset, wraps mod 2^16

## Operation
- Accept occurs when in_valid && in_ready. in_ready is 1 only in IDLE. All four addresses are latched on accept.
- FSM states: IDLE, RD_P, RD_Q, RD_R, RD_S, LAST, WB, OUT.
  - IDLE→RD_P on accept.
  - RD_P→RD_Q→RD_R→RD_S→LAST→WB→OUT, unconditionally, one cycle each.
  - OUT→IDLE on out_ready.
- RD_P, RD_Q, RD_R, RD_S each drive mem_rd_en=1 with mem_addr set to p, q, r, s respectively.
- Accumulator acc, DW bits, all arithmetic mod 2^DW:
  - RD_Q: acc ← mem_rdata (T[p])
  - RD_R: acc ← acc + mem_rdata (T[q])
  - RD_S: acc ← acc ^ mem_rdata (T[r])
  - LAST: acc ← acc + mem_rdata (T[s])
  - Result = ((T[p]+T[q]) ^ T[r]) + T[s].
- WB: mem_wr_en=1, mem_addr=p, mem_wdata=acc.
- OUT: out_valid=1 and out_data=acc. Both are held stable until out_ready. num_count increments on the out_valid && out_ready cycle.
- Duplicate or equal addresses are legal. All reads complete before the write, so there is no read/write hazard.
- mem_rd_en and mem_wr_en are never both high. Outside the states listed above, mem_addr and mem_wdata are 0.

## Timing
- Reset values: in_ready=0 during reset (IDLE after release gives 1), out_valid=0, out_data=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, num_count=0, acc=0, state=IDLE.
- Reset mid-operation: the transaction is discarded with no write-back. RAM contents are untouched. in_ready=1 in the first cycle after release.
- Latency: with accept in cycle 0, out_valid first goes high in cycle 7 (6 with write-back compiled out).
- Minimum issue interval is 8 cycles: the next accept is possible in cycle 8 if out_ready=1 in cycle 7.
- Backpressure: with out_ready low, the FSM stays in OUT indefinitely, in_ready=0, and no RAM traffic occurs.

## Configuration
- RNG_WRITEBACK_EN defined: WB state present, behaviour as above.
- RNG_WRITEBACK_EN undefined:
  - WB is removed and LAST→OUT directly.
  - mem_wr_en is tied 0 and mem_wdata is tied 0.
  - Latency is 6 and the minimum interval is 7 cycles.

## Structure
- Shared package rng_pkg holds:
  - AW/DW default constants
  - the state typedef enum (IDLE..OUT)
  - the 16-bit count width constant
- Single module with no sub-module. The combine step is four register updates and does not justify its own block.

## Test plan
- Preload T[1]=5, T[2]=3, T[3]=0xF, T[4]=1; quad (1,2,3,4), out_ready=1 → out_data=0x8 in cycle 7, T[1]=0x8 afterwards, num_count=1.
- Preload T[0]=0xFFFFFFFF; quad (0,0,0,0) → out_data=0x00000000 (wrap), T[0]=0, reads precede write.
- Same as first case, but out_ready held low 3 cycles after out_valid → out_valid and out_data=0x8 stable, in_ready=0, no mem strobes; handshake in the 4th cycle, in_ready=1 next cycle.
- Assert reset while in RD_R → all outputs 0, T[1] unchanged (5); then a fresh quad (1,2,3,4) yields 0x8.
- Back-to-back quads with in_valid and out_ready held high → accepts every 8 cycles, num_count increments by 1 per result.
- RNG_WRITEBACK_EN undefined, first case → out_data=0x8 in cycle 6, mem_wr_en never asserted, T[1] stays 5.

Source files
------------

// File: rtl/rng_pkg.sv
//==============================================================================
// Module      : rng_pkg
// Description : Shared constants and state encoding for the uniform RNG
//               table reader (address/data widths, count width, FSM states).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rng_pkg;

   // default table geometry: 1024 entries of 32-bit words
   localparam int unsigned c_aw_default = 10;
   localparam int unsigned c_dw_default = 32;

   // width of the delivered-results counter (wraps naturally)
   localparam int unsigned c_cnt_w = 16;

   // reader FSM states, in issue order
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_P = 3'd1,
      RD_Q = 3'd2,
      RD_R = 3'd3,
      RD_S = 3'd4,
      LAST = 3'd5,
      WB   = 3'd6,
      OUT  = 3'd7
   } state_e;

endpackage : rng_pkg

`default_nettype wire

// File: rtl/rng_table_reader_if.sv
//==============================================================================
// Module      : rng_table_reader_if
// Description : Bundle of the table reader's address-quad input handshake,
//               single-port RAM bus and result output handshake.
//               master = address generator / RAM / downstream side,
//               slave  = the table reader itself.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rng_table_reader_if
   import rng_pkg::*;
#(
   parameter int unsigned AW = c_aw_default,
   parameter int unsigned DW = c_dw_default
);

   // address quad from the address generator
   logic                in_valid;
   logic                in_ready;
   logic [AW-1:0]       p_addr;
   logic [AW-1:0]       q_addr;
   logic [AW-1:0]       r_addr;
   logic [AW-1:0]       s_addr;

   // single-port synchronous RAM
   logic [AW-1:0]       mem_addr;
   logic                mem_rd_en;
   logic                mem_wr_en;
   logic [DW-1:0]       mem_wdata;
   logic [DW-1:0]       mem_rdata;

   // random word output
   logic                out_valid;
   logic                out_ready;
   logic [DW-1:0]       out_data;
   logic [c_cnt_w-1:0]  num_count;

   modport master (
      output in_valid, p_addr, q_addr, r_addr, s_addr,
      output mem_rdata,
      output out_ready,
      input  in_ready,
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      input  out_valid, out_data, num_count
   );

   modport slave (
      input  in_valid, p_addr, q_addr, r_addr, s_addr,
      input  mem_rdata,
      input  out_ready,
      output in_ready,
      output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      output out_valid, out_data, num_count
   );

endinterface : rng_table_reader_if

`default_nettype wire

// File: rtl/rng_table_reader.sv
//==============================================================================
// Module      : rng_table_reader
// Description : Reads four table words T[p], T[q], T[r], T[s] from a
//               single-port synchronous RAM, combines them as
//               ((T[p] + T[q]) ^ T[r]) + T[s], optionally writes the result
//               back into slot p, and delivers it over valid/ready.
//               Macro RNG_WRITEBACK_EN : when defined, the WB state writes the
//               result back to T[p]; when undefined, WB is skipped and the
//               RAM write strobe/data are tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rng_table_reader
   import rng_pkg::*;
#(
   parameter int unsigned AW = c_aw_default,
   parameter int unsigned DW = c_dw_default
) (
   input  logic                clk,
   input  logic                reset,
   rng_table_reader_if.slave   bus
);

   // state encodings kept as plain vectors for legacy tools
   localparam logic [2:0] c_idle = IDLE;
   localparam logic [2:0] c_rd_p = RD_P;
   localparam logic [2:0] c_rd_q = RD_Q;
   localparam logic [2:0] c_rd_r = RD_R;
   localparam logic [2:0] c_rd_s = RD_S;
   localparam logic [2:0] c_last = LAST;
`ifdef RNG_WRITEBACK_EN
   localparam logic [2:0] c_wb   = WB;
`endif
   localparam logic [2:0] c_out  = OUT;

   localparam logic [c_cnt_w-1:0] c_cnt_one = 1;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [AW-1:0]       r_p;
   logic [AW-1:0]       r_q;
   logic [AW-1:0]       r_r;
   logic [AW-1:0]       r_s;
   logic [DW-1:0]       r_acc;
   logic [c_cnt_w-1:0]  r_count;
   logic                w_accept;
   logic                w_deliver;

   // in_ready is forced low while reset is held so no quad slips in
   assign bus.in_ready = (r_state == c_idle) && !reset;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_deliver    = (r_state == c_out) && bus.out_ready;
   assign bus.num_count = r_count;

   // next-state: fixed read sequence, then optional write-back, then hold in OUT
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: if (w_accept) w_state_nxt = c_rd_p;
         c_rd_p: w_state_nxt = c_rd_q;
         c_rd_q: w_state_nxt = c_rd_r;
         c_rd_r: w_state_nxt = c_rd_s;
         c_rd_s: w_state_nxt = c_last;
`ifdef RNG_WRITEBACK_EN
         c_last: w_state_nxt = c_wb;
         c_wb:   w_state_nxt = c_out;
`else
         c_last: w_state_nxt = c_out;
`endif
         c_out:  if (bus.out_ready) w_state_nxt = c_idle;
         default: w_state_nxt = c_idle;
      endcase
   end

   // state register; reset abandons any in-flight quad before its write-back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_idle;
      else       r_state <= w_state_nxt;
   end

   // capture the address quad on accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p <= '0;
         r_q <= '0;
         r_r <= '0;
         r_s <= '0;
      end else if (w_accept) begin
         r_p <= bus.p_addr;
         r_q <= bus.q_addr;
         r_r <= bus.r_addr;
         r_s <= bus.s_addr;
      end
   end

   // fold each returning RAM word into the accumulator (read data lags by one state)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else begin
         case (r_state)
            c_rd_q:  r_acc <= bus.mem_rdata;
            c_rd_r:  r_acc <= r_acc + bus.mem_rdata;
            c_rd_s:  r_acc <= r_acc ^ bus.mem_rdata;
            c_last:  r_acc <= r_acc + bus.mem_rdata;
            default: r_acc <= r_acc;
         endcase
      end
   end

   // count delivered results
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_count <= '0;
      else if (w_deliver) r_count <= r_count + c_cnt_one;
   end

   // RAM strobes and output drive decoded from state; everything idles at zero
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_rd_en = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.mem_wdata = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      case (r_state)
         c_rd_p: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = r_p;
         end
         c_rd_q: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = r_q;
         end
         c_rd_r: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = r_r;
         end
         c_rd_s: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = r_s;
         end
`ifdef RNG_WRITEBACK_EN
         c_wb: begin
            bus.mem_wr_en = 1'b1;
            bus.mem_addr  = r_p;
            bus.mem_wdata = r_acc;
         end
`endif
         c_out: begin
            bus.out_valid = 1'b1;
            bus.out_data  = r_acc;
         end
         default: begin
            bus.mem_addr  = '0;
         end
      endcase
   end

endmodule : rng_table_reader

`default_nettype wire

// File: tb/tb_rng_table_reader.sv
//==============================================================================
// Module      : tb_rng_table_reader
// Description : Self-checking bench for rng_table_reader with a behavioural
//               single-port RAM, an expected-result queue and a monitor.
//               Honours RNG_WRITEBACK_EN for latency and write-back results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rng_table_reader;
   import rng_pkg::*;

`ifdef RNG_WRITEBACK_EN
   localparam int  LAT   = 7;
   localparam bit  WB_ON = 1'b1;
`else
   localparam int  LAT   = 6;
   localparam bit  WB_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rng_table_reader_if #(.AW(10), .DW(32)) bus ();

   rng_table_reader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // single-port synchronous RAM model
   logic [31:0] tmem [0:1023];
   always @(posedge clk) begin
      if (bus.mem_wr_en) tmem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= tmem[bus.mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_chk   = 0;
   int          n_pass  = 0;
   int          wr_seen = 0;
   int          clash   = 0;
   logic [31:0] exp_q [$];
   int          acc_q [$];
   logic        prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s: bound expired / unexpected event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: latency, result data, strobe activity
   always @(negedge clk) begin
      if (bus.mem_wr_en) wr_seen++;
      if (bus.mem_rd_en && bus.mem_wr_en) clash++;
      if (!reset && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && !prev_valid) begin
         if (acc_q.size() == 0) fail("latency_no_accept");
         else chk("latency", cyc - acc_q.pop_front(), LAT);
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) fail("out_unexpected");
         else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_valid = bus.out_valid;
   end

   task automatic issue(input logic [9:0] p, q, r, s, input logic [31:0] exp);
      int n = 0;
      while (!bus.in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!bus.in_ready) fail("issue_timeout");
      bus.p_addr   = p;
      bus.q_addr   = q;
      bus.r_addr   = r;
      bus.s_addr   = s;
      bus.in_valid = 1'b1;
      exp_q.push_back(exp);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!bus.in_ready) fail("idle_timeout");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b_exp [4];
      int          last_acc;

      bus.in_valid  = 1'b0;
      bus.p_addr    = '0;
      bus.q_addr    = '0;
      bus.r_addr    = '0;
      bus.s_addr    = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 1024; i++) tmem[i] <= 32'h0;
      @(posedge clk);
      tmem[0] <= 32'hFFFF_FFFF;
      tmem[1] <= 32'd5;
      tmem[2] <= 32'd3;
      tmem[3] <= 32'hF;
      tmem[4] <= 32'd1;

      // reset values
      @(negedge clk);
      chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  bus.out_data,           32'd0);
      chk("rst_rd_en",     {31'b0, bus.mem_rd_en}, 32'd0);
      chk("rst_wr_en",     {31'b0, bus.mem_wr_en}, 32'd0);
      chk("rst_mem_addr",  {22'b0, bus.mem_addr},  32'd0);
      chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
      chk("rst_num_count", {16'b0, bus.num_count}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // basic quad: ((5+3)^F)+1 = 8
      issue(10'd1, 10'd2, 10'd3, 10'd4, 32'h8);
      wait_idle();
      chk("t1_after", tmem[1], WB_ON ? 32'h8 : 32'h5);
      chk("count_1", {16'b0, bus.num_count}, 32'd1);

      // all-equal addresses with wraparound: ((F..F+F..F)^F..F)+F..F = 0
      issue(10'd0, 10'd0, 10'd0, 10'd0, 32'h0);
      wait_idle();
      chk("t0_after", tmem[0], WB_ON ? 32'h0 : 32'hFFFF_FFFF);
      chk("count_2", {16'b0, bus.num_count}, 32'd2);

      // backpressure: hold OUT for three cycles
      tmem[1] <= 32'd5;
      bus.out_ready = 1'b0;
      issue(10'd1, 10'd2, 10'd3, 10'd4, 32'h8);
      begin
         int n = 0;
         while (!bus.out_valid && n < 40) begin
            tick();
            n++;
         end
         if (!bus.out_valid) fail("bp_wait_valid");
      end
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid",    {31'b0, bus.out_valid}, 32'd1);
         chk("bp_data",     bus.out_data,           32'h8);
         chk("bp_in_ready", {31'b0, bus.in_ready},  32'd0);
         chk("bp_strobes",  {31'b0, bus.mem_rd_en | bus.mem_wr_en}, 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
      chk("count_3", {16'b0, bus.num_count}, 32'd3);

      // reset while in RD_R discards the quad without write-back
      tmem[1] <= 32'd5;
      tick();
      issue(10'd1, 10'd2, 10'd3, 10'd4, 32'h8);
      tick();
      tick();
      reset = 1'b1;
      exp_q.delete();
      acc_q.delete();
      #1;
      chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("mid_rst_rd_en",     {31'b0, bus.mem_rd_en}, 32'd0);
      chk("mid_rst_mem_addr",  {22'b0, bus.mem_addr},  32'd0);
      chk("mid_rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
      chk("mid_rst_count",     {16'b0, bus.num_count}, 32'd0);
      tick();
      tick();
      chk("mid_rst_t1", tmem[1], 32'd5);
      reset = 1'b0;
      #1;
      chk("mid_rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
      issue(10'd1, 10'd2, 10'd3, 10'd4, 32'h8);
      wait_idle();
      chk("count_after_rst", {16'b0, bus.num_count}, 32'd1);

      // back-to-back: T5=1,T6=2,T7=0,T8=0, p=5 rewritten each pass when enabled
      tmem[5] <= 32'd1;
      tmem[6] <= 32'd2;
      tmem[7] <= 32'd0;
      tmem[8] <= 32'd0;
      tick();
      if (WB_ON) begin
         b2b_exp[0] = 32'd3; b2b_exp[1] = 32'd5; b2b_exp[2] = 32'd7; b2b_exp[3] = 32'd9;
      end else begin
         b2b_exp[0] = 32'd3; b2b_exp[1] = 32'd3; b2b_exp[2] = 32'd3; b2b_exp[3] = 32'd3;
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(b2b_exp[k]);
      bus.p_addr   = 10'd5;
      bus.q_addr   = 10'd6;
      bus.r_addr   = 10'd7;
      bus.s_addr   = 10'd8;
      bus.in_valid = 1'b1;
      last_acc     = 0;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         while (!bus.in_ready && n < 40) begin
            tick();
            n++;
         end
         if (!bus.in_ready) fail("b2b_timeout");
         if (k > 0) chk("b2b_interval", cyc - last_acc, LAT + 1);
         last_acc = cyc;
         tick();
      end
      bus.in_valid = 1'b0;
      wait_idle();
      chk("count_b2b", {16'b0, bus.num_count}, 32'd5);

      // global properties
      chk("rd_wr_clash", clash, 32'd0);
      chk("write_count", wr_seen, WB_ON ? 32'd8 : 32'd0);
      chk("exp_q_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_rng_table_reader

`default_nettype wire
